// File: rtl/wb_retire_queue_pkg.sv
// wb_retire_queue_pkg: shared widths and writeback-bus field offsets
// Bus layout, MSB first: {gr_strb[STRB_W], dest[ADDR_W], result[DATA_W], pc[PC_W]}
package wb_retire_queue_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_BUS_W  = DEF_DATA_W / 8 + DEF_ADDR_W + DEF_DATA_W + DEF_PC_W;
    function automatic int bus_w(input int data_w, input int addr_w, input int pc_w);
        return data_w / 8 + addr_w + data_w + pc_w;
    endfunction
    function automatic int off_res(input int pc_w);
        return pc_w;
    endfunction
    function automatic int off_dest(input int data_w, input int pc_w);
        return pc_w + data_w;
    endfunction
    function automatic int off_strb(input int data_w, input int addr_w, input int pc_w);
        return pc_w + data_w + addr_w;
    endfunction
endpackage

// File: rtl/wb_retire_queue_if.sv
// wb_retire_queue_if: MEM-to-WB valid/allowin handshake carrying the writeback bus
// Signals: ws_allowin (WB->MEM), ms_to_ws_valid and ms_to_ws_bus (MEM->WB)
interface wb_retire_queue_if
    import wb_retire_queue_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W
);
    logic             ws_allowin;
    logic             ms_to_ws_valid;
    logic [BUS_W-1:0] ms_to_ws_bus;
    modport master (input ws_allowin, output ms_to_ws_valid, output ms_to_ws_bus);
    modport slave  (output ws_allowin, input ms_to_ws_valid, input ms_to_ws_bus);
endinterface

// File: rtl/wb_retire_queue_fifo.sv
// wb_retire_fifo: DEPTH-entry circular buffer of W-bit entries
// Ports: clk, resetn (async active-low); i_push/i_din write at wr_ptr, i_pop advances rd_ptr;
// o_count, o_rd_ptr, o_head (entry at rd_ptr), o_ents (all slots flattened, slot g at [g*W +: W]),
// o_valid (per physical slot, set when the slot holds a queued entry).
// The caller must never push when full or pop when empty.
module wb_retire_fifo #(
    parameter int W     = 73,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_push,
    input  logic [W-1:0]       i_din,
    input  logic               i_pop,
    output logic [PTR_W:0]     o_count,
    output logic [PTR_W-1:0]   o_rd_ptr,
    output logic [W-1:0]       o_head,
    output logic [DEPTH*W-1:0] o_ents,
    output logic [DEPTH-1:0]   o_valid
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
        end
    end
    // Payload is deliberately not reset; o_valid masks stale slots.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end
    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;
    assign o_head   = r_mem[r_rd_ptr];
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_ents[g*W +: W] = r_mem[g];
        // Slot age relative to the head, modulo DEPTH, must fall inside the occupied range.
        assign o_valid[g] = {1'b0, PTR_W'(g) - r_rd_ptr} < r_count;
    end
endmodule

// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order writeback retire queue with byte-strobed RF port, forwarding and trace
// Ports: clk, resetn (async active-low); ms (slave side of the MEM->WB handshake);
// rf_ready/rf_we/rf_waddr/rf_wdata shared RF write port; ds_rs_addr/ds_rt_addr lookups returning
// rs_/rt_ hit, data, partial; debug_wb_* trace outputs, nonzero only on retire cycles.
module wb_retire_queue
    import wb_retire_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int STRB_W = DATA_W / 8
)(
    input  logic              clk,
    input  logic              resetn,
    wb_retire_queue_if.slave  ms,
    input  logic              rf_ready,
    output logic [STRB_W-1:0] rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] ds_rs_addr,
    input  logic [ADDR_W-1:0] ds_rt_addr,
    output logic              rs_hit,
    output logic              rt_hit,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_partial,
    output logic              rt_partial,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [STRB_W-1:0] debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);
    localparam int BUS_W  = bus_w(DATA_W, ADDR_W, PC_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int O_RES  = off_res(PC_W);
    localparam int O_DEST = off_dest(DATA_W, PC_W);
    localparam int O_STRB = off_strb(DATA_W, ADDR_W, PC_W);
    logic [PTR_W:0]         w_count;
    logic [PTR_W-1:0]       w_rd_ptr;
    logic [BUS_W-1:0]       w_head;
    logic [DEPTH*BUS_W-1:0] w_ents;
    logic [DEPTH-1:0]       w_valid;
    logic                   w_allowin;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_nonempty;
    logic [ADDR_W-1:0]      w_head_dest;
    logic [STRB_W-1:0]      w_head_eff;
    logic [ADDR_W-1:0]      w_addr [2];
    logic                   w_hit  [2];
    logic [DATA_W-1:0]      w_data [2];
    logic                   w_part [2];
    wb_retire_fifo #(.W(BUS_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .i_push   (w_push),
        .i_din    (ms.ms_to_ws_bus),
        .i_pop    (w_pop),
        .o_count  (w_count),
        .o_rd_ptr (w_rd_ptr),
        .o_head   (w_head),
        .o_ents   (w_ents),
        .o_valid  (w_valid)
    );
    // Allowin depends only on occupancy, so rf_ready never reaches the MEM stage combinationally.
    assign w_allowin     = w_count != (PTR_W+1)'(DEPTH);
    assign ms.ws_allowin = w_allowin;
    assign w_push        = ms.ms_to_ws_valid && w_allowin;
    assign w_nonempty    = w_count != '0;
    assign w_head_dest   = w_head[O_DEST +: ADDR_W];
    // Writes to r0 are squashed to a zero strobe but still retire for trace ordering.
    assign w_head_eff    = (w_head_dest == '0) ? '0 : w_head[O_STRB +: STRB_W];
    assign w_pop         = w_nonempty && (w_head_eff == '0 || rf_ready);
    assign rf_we         = (w_nonempty && rf_ready) ? w_head_eff : '0;
    assign rf_waddr      = w_head_dest;
    assign rf_wdata      = w_head[O_RES +: DATA_W];
    assign debug_wb_pc       = w_pop ? w_head[0 +: PC_W] : '0;
    assign debug_wb_rf_wen   = w_pop ? w_head_eff : '0;
    assign debug_wb_rf_wnum  = w_pop ? w_head_dest : '0;
    assign debug_wb_rf_wdata = w_pop ? w_head[O_RES +: DATA_W] : '0;
    // Walk entries oldest to youngest so the last match seen is the youngest writer.
    always_comb begin
        logic [PTR_W-1:0]  s;
        logic [ADDR_W-1:0] dst;
        logic [STRB_W-1:0] stb;
        s = '0;
        dst = '0;
        stb = '0;
        w_addr[0] = ds_rs_addr;
        w_addr[1] = ds_rt_addr;
        for (int p = 0; p < 2; p++) begin
            w_hit[p]  = 1'b0;
            w_data[p] = '0;
            w_part[p] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                s   = w_rd_ptr + PTR_W'(i);
                dst = w_ents[s*BUS_W + O_DEST +: ADDR_W];
                stb = w_ents[s*BUS_W + O_STRB +: STRB_W];
                if (w_valid[s] && dst != '0 && stb != '0 && dst == w_addr[p]) begin
                    w_hit[p]  = 1'b1;
                    w_data[p] = w_ents[s*BUS_W + O_RES +: DATA_W];
                    w_part[p] = stb != '1;
                end
            end
        end
    end
    assign rs_hit     = w_hit[0];
    assign rt_hit     = w_hit[1];
    assign rs_data    = w_data[0];
    assign rt_data    = w_data[1];
    assign rs_partial = w_part[0];
    assign rt_partial = w_part[1];
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb_wb_retire_queue: directed self-checking bench for wb_retire_queue at default parameters
module tb_wb_retire_queue;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rf_ready = 1'b0;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ds_rs_addr = '0;
    logic [4:0]  ds_rt_addr = '0;
    logic        rs_hit, rt_hit, rs_partial, rt_partial;
    logic [31:0] rs_data, rt_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    int checks = 0;
    int errors = 0;
    wb_retire_queue_if #(.BUS_W(73)) mif ();
    wb_retire_queue dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms                (mif),
        .rf_ready          (rf_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ds_rs_addr        (ds_rs_addr),
        .ds_rt_addr        (ds_rt_addr),
        .rs_hit            (rs_hit),
        .rt_hit            (rt_hit),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .rs_partial        (rs_partial),
        .rt_partial        (rt_partial),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    function automatic logic [72:0] mk(input logic [3:0] s, input logic [4:0] d, input logic [31:0] r, input logic [31:0] p);
        return {s, d, r, p};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [72:0] b);
        mif.ms_to_ws_valid = 1'b1;
        mif.ms_to_ws_bus = b;
        step();
    endtask
    initial begin
        mif.ms_to_ws_valid = 1'b0;
        mif.ms_to_ws_bus = '0;
        #2;
        chk("rst_allowin", mif.ws_allowin, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_hit", rs_hit, 0);
        chk("rst_dbg_pc", debug_wb_pc, 0);
        #10 resetn = 1'b1;
        step();
        // single entry, 1-cycle latency
        rf_ready = 1'b1;
        send(mk(4'hF, 5'd5, 32'h1234_5678, 32'hBFC0_0000));
        mif.ms_to_ws_valid = 1'b0;
        #1;
        chk("t1_we", rf_we, 4'hF);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'h1234_5678);
        chk("t1_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
        chk("t1_dbg_wen", debug_wb_rf_wen, 4'hF);
        step();
        chk("t1_empty_we", rf_we, 0);
        chk("t1_empty_pc", debug_wb_pc, 0);
        chk("t1_empty_allowin", mif.ws_allowin, 1);
        // fill to full while RF port stalled
        rf_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(mk(4'hF, 5'(k + 1), 32'hC000_0000 + k, 32'h100 + k));
        chk("t2_full", mif.ws_allowin, 0);
        ds_rs_addr = 5'd3;
        send(mk(4'hF, 5'd5, 32'hC000_0004, 32'h104));
        chk("t2_full_held", mif.ws_allowin, 0);
        chk("t2_stall_we", rf_we, 0);
        chk("t2_stall_pc", debug_wb_pc, 0);
        chk("t2_fwd_hit", rs_hit, 1);
        chk("t2_fwd_data", rs_data, 32'hC000_0002);
        rf_ready = 1'b1;
        #1;
        chk("t2_we", rf_we, 4'hF);
        chk("t2_pc0", debug_wb_pc, 32'h100);
        step();
        chk("t2_allowin", mif.ws_allowin, 1);
        chk("t2_pc1", debug_wb_pc, 32'h101);
        step();
        mif.ms_to_ws_valid = 1'b0;
        #1;
        chk("t2_pc2", debug_wb_pc, 32'h102);
        step();
        chk("t2_pc3", debug_wb_pc, 32'h103);
        step();
        chk("t2_pc4", debug_wb_pc, 32'h104);
        chk("t2_waddr4", rf_waddr, 5);
        step();
        chk("t2_empty", rf_we, 0);
        // youngest-match forwarding and partial strobes
        rf_ready = 1'b0;
        send(mk(4'hF, 5'd8, 32'hAAAA_AAAA, 32'h300));
        send(mk(4'hF, 5'd8, 32'hBBBB_BBBB, 32'h304));
        send(mk(4'b0011, 5'd9, 32'h0000_9999, 32'h308));
        mif.ms_to_ws_valid = 1'b0;
        ds_rs_addr = 5'd8;
        ds_rt_addr = 5'd9;
        #1;
        chk("t3_rs_hit", rs_hit, 1);
        chk("t3_rs_data", rs_data, 32'hBBBB_BBBB);
        chk("t3_rs_part", rs_partial, 0);
        chk("t3_rt_hit", rt_hit, 1);
        chk("t3_rt_data", rt_data, 32'h0000_9999);
        chk("t3_rt_part", rt_partial, 1);
        rf_ready = 1'b1;
        #1;
        chk("t3_wdata0", rf_wdata, 32'hAAAA_AAAA);
        chk("t3_rs_data_ret", rs_data, 32'hBBBB_BBBB);
        step();
        chk("t3_wdata1", rf_wdata, 32'hBBBB_BBBB);
        chk("t3_rs_hit_ret", rs_hit, 1);
        step();
        chk("t3_we_part", rf_we, 4'b0011);
        chk("t3_rs_gone", rs_hit, 0);
        chk("t3_rt_ret_hit", rt_hit, 1);
        step();
        chk("t3_rt_empty", rt_hit, 0);
        // dest 0 retires without RF port
        rf_ready = 1'b0;
        ds_rs_addr = 5'd0;
        send(mk(4'hF, 5'd0, 32'hDEAD_BEEF, 32'h200));
        mif.ms_to_ws_valid = 1'b0;
        #1;
        chk("t4_we", rf_we, 0);
        chk("t4_dbg_wen", debug_wb_rf_wen, 0);
        chk("t4_dbg_pc", debug_wb_pc, 32'h200);
        chk("t4_r0_hit", rs_hit, 0);
        step();
        chk("t4_drained_pc", debug_wb_pc, 0);
        chk("t4_allowin", mif.ws_allowin, 1);
        // wrap pointers, then reset mid-operation
        for (int k = 0; k < 3; k++) send(mk(4'hF, 5'(10 + k), 32'h4400 + k, 32'h400 + 4 * k));
        mif.ms_to_ws_valid = 1'b0;
        ds_rs_addr = 5'd12;
        #1;
        chk("t5_pre_hit", rs_hit, 1);
        chk("t5_pre_data", rs_data, 32'h4402);
        rf_ready = 1'b1;
        resetn = 1'b0;
        #1;
        chk("t5_rst_allowin", mif.ws_allowin, 1);
        chk("t5_rst_hit", rs_hit, 0);
        chk("t5_rst_we", rf_we, 0);
        chk("t5_rst_pc", debug_wb_pc, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step();
        chk("t5_post_we", rf_we, 0);
        chk("t5_post_pc", debug_wb_pc, 0);
        send(mk(4'hF, 5'd7, 32'h77, 32'h500));
        mif.ms_to_ws_valid = 1'b0;
        #1;
        chk("t5_new_we", rf_we, 4'hF);
        chk("t5_new_waddr", rf_waddr, 7);
        chk("t5_new_pc", debug_wb_pc, 32'h500);
        step();
        chk("t5_final_we", rf_we, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised writeback stage that replaces the single-register WB stage with a DEPTH-entry in-order retire queue. It accepts MEM-stage results over the valid/allowin handshake, retires them to the register file in program order through a shared, stallable write port with per-byte strobes, and provides youngest-match forwarding lookups to the decode stage. It also drives the trace debug interface at the moment each instruction retires.

## Interface
- DATA_W, 32, register/data width; must be a multiple of 8.
- ADDR_W, 5, register number width.
- PC_W, 32, PC width.
- DEPTH, 4, queue entries; power of two, at least 2.
- STRB_W, DATA_W/8, derived byte-strobe width; not overridable.
- Bus widths: BUS_W = STRB_W+ADDR_W+DATA_W+PC_W, 73 at defaults.
- clk  in  1  sole clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ws_allowin  out  1  queue can accept an entry this cycle.
- ms_to_ws_valid  in  1  MEM stage presents a valid entry.
- ms_to_ws_bus  in  BUS_W  {gr_strb[STRB_W], dest[ADDR_W], result[DATA_W], pc[PC_W]}, MSB first.
- rf_ready  in  1  shared RF write port is available this cycle.
- rf_we  out  STRB_W  byte write strobes of head entry.
- rf_waddr  out  ADDR_W  head destination.
- rf_wdata  out  DATA_W  head result.
- ds_rs_addr, ds_rt_addr  in  ADDR_W each  decode lookup addresses.
- rs_hit, rt_hit  out  1 each  a pending entry writes that register.
- rs_data, rt_data  out  DATA_W each  result of youngest matching entry.
- rs_partial, rt_partial  out  1 each  youngest match has a strobe that is not all ones; decode must stall.
- debug_wb_pc  out  PC_W; debug_wb_rf_wen  out  STRB_W; debug_wb_rf_wnum  out  ADDR_W; debug_wb_rf_wdata  out  DATA_W.

## Operation
- Storage: circular buffer with rd_ptr and wr_ptr of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push: ms_to_ws_valid && ws_allowin writes the bus to entry[wr_ptr] and advances wr_ptr.
- Effective strobe = gr_strb, forced to 0 when dest==0. Zero-strobe entries still pass through the queue so that trace order is preserved.
- Retire condition: count!=0 && (eff_strb==0 || rf_ready). A retire advances rd_ptr.
- rf_we = eff_strb of the head when count!=0 && rf_ready, else 0. rf_waddr and rf_wdata come from the head; their values are don't-care when rf_we==0.
- Debug outputs are driven only on retire cycles: debug_wb_pc = head pc, wen = eff_strb, wnum = dest, wdata = result. On all other cycles every debug output is 0.
- Forwarding, per port:
  - Search all valid entries from youngest (wr_ptr-1) to oldest. A candidate needs eff_strb!=0 and dest==addr.
  - hit = a candidate exists; data = youngest candidate's result; partial = that candidate's eff_strb is not all ones.
  - Lookup address 0 never hits. With no hit, data and partial are 0.
- An entry retiring this cycle still participates in forwarding this cycle.

## Timing
- ws_allowin = (count != DEPTH). There is no combinational path from rf_ready to ws_allowin.
- Minimum latency is 1 cycle: an entry pushed at edge N can retire during cycle N+1 if rf_ready=1.
- Simultaneous push and retire leave count unchanged.
- Full: push is blocked even if a retire happens in the same cycle. Empty: no retire, rf_we=0, all debug outputs 0, no forwarding hits.
- rf_ready low holds the head with a nonzero strobe indefinitely. A zero-strobe head retires regardless of rf_ready.
- Reset, including assertion mid-operation: count, rd_ptr and wr_ptr go to 0 immediately; all queued entries are discarded. Entry payload storage is not reset.
- Output values while resetn is low: ws_allowin=1; rf_we, all hits and partials, and all debug outputs are 0.
- Forwarding outputs and rf outputs are combinational from queue state and the lookup inputs; there are no registered outputs.

## Structure
- Add BUS_W, the bus field offsets and STRB_W macros to the shared mycpu.h header alongside the existing stage-bus widths.
- One sub-module: wb_retire_fifo, a parametrised circular buffer exposing push, pop, count, head fields and a flattened entry/valid array. The forwarding search stays in the top module.

## Test plan
- Single entry {strb=4'hF, dest=5, result=32'h1234_5678, pc=32'hBFC0_0000}, rf_ready=1 → next cycle rf_we=4'hF, waddr=5, debug_wb_pc=32'hBFC0_0000; queue empty the cycle after.
- rf_ready held 0, push 5 entries with nonzero strobes at DEPTH=4 → ws_allowin drops after the 4th push; the 5th is held by MEM. Raise rf_ready → entries retire one per cycle in PC order and the 5th is accepted.
- Two queued writes to r8 (older 32'hAAAA_AAAA, younger 32'hBBBB_BBBB), ds_rs_addr=8 → rs_hit=1, rs_data=32'hBBBB_BBBB, rs_partial=0.
- Youngest r9 write with strb=4'b0011 → rt_partial=1 when ds_rt_addr=9. A dest=0 write with strb=4'hF → rf_we=0 and debug wen=0, and it retires with rf_ready=0.
- Fill to 3 entries with wr_ptr wrapped past DEPTH-1, then pulse resetn low for one cycle → count=0 and ws_allowin=1 immediately; no stale writes appear afterwards.
